// File: rtl/gnr_pkg.sv
// rtl/gnr_pkg.sv - shared types and defaults for the GNR attractor controller
package gnr_pkg;

   localparam int N_NODES_DEF = 188;
   localparam int CNT_W_DEF   = 32;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      F_STEP,
      F_CHK,
      P_STEP,
      P_CHK,
      DONE
   } gnr_state_t;

   typedef struct packed {
      logic [CNT_W_DEF-1:0]   detect_steps;
      logic [CNT_W_DEF-1:0]   period;
      logic [N_NODES_DEF-1:0] attractor;
      logic                   timeout;
   } gnr_result_t;

endpackage

// File: rtl/gnr_vec_cmp.sv
// rtl/gnr_vec_cmp.sv - combinational full-width equality compare of two state vectors
module gnr_vec_cmp #(
   parameter int W = 188
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         eq_o
);

   assign eq_o = (a_i == b_i);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - Floyd cycle-detection run controller for a GNR node array
module gnr_attractor_ctrl
   import gnr_pkg::*;
#(
   parameter int N_NODES   = N_NODES_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int MAX_STEPS = 2**20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_NODES-1:0] init_vec,
   output logic               reset_nos,
   output logic [N_NODES-1:0] init_state,
   output logic               start_s0,
   output logic               start_s1,
   input  logic [N_NODES-1:0] s0_vec,
   input  logic [N_NODES-1:0] s1_vec,
   output logic               busy,
   output logic               result_valid,
   input  logic               result_ack,
   output logic [CNT_W-1:0]   detect_steps,
   output logic [CNT_W-1:0]   period,
   output logic [N_NODES-1:0] attractor,
   output logic               timeout
);

   localparam int                KW     = CNT_W + 1;
   localparam logic [CNT_W-1:0]  MAX_K  = CNT_W'(MAX_STEPS);
   localparam logic [CNT_W:0]    MAX_KP = KW'(MAX_STEPS);

   gnr_state_t         state_q;
   logic [N_NODES-1:0] init_q, attr_q;
   logic [CNT_W-1:0]   k_q, p_q, det_q, per_q;
   logic [CNT_W-1:0]   k_d, p_d;
   logic [CNT_W:0]     kp_sum;
   logic               busy_q, valid_q, tmo_q, rnos_q, s0_q, s1_q;
   logic               tort_eq, hare_eq;

   gnr_vec_cmp #(.W(N_NODES)) u_cmp_tort (.a_i(s0_vec), .b_i(s1_vec), .eq_o(tort_eq));
   gnr_vec_cmp #(.W(N_NODES)) u_cmp_hare (.a_i(s1_vec), .b_i(attr_q), .eq_o(hare_eq));

   // Step counters stick at all-ones instead of wrapping.
   assign k_d    = (&k_q) ? k_q : k_q + CNT_W'(1);
   assign p_d    = (&p_q) ? p_q : p_q + CNT_W'(1);
   assign kp_sum = {1'b0, k_q} + {1'b0, p_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         init_q  <= '0;
         attr_q  <= '0;
         k_q     <= '0;
         p_q     <= '0;
         det_q   <= '0;
         per_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         tmo_q   <= 1'b0;
         rnos_q  <= 1'b0;
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
      end else begin
         // Strobes are one-cycle pulses, raised on the transition into their state.
         rnos_q <= 1'b0;
         s0_q   <= 1'b0;
         s1_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  init_q  <= init_vec;
                  busy_q  <= 1'b1;
                  k_q     <= '0;
                  p_q     <= '0;
                  tmo_q   <= 1'b0;
                  rnos_q  <= 1'b1;
                  state_q <= INIT;
               end
            end
            INIT: begin
               s0_q    <= 1'b1;
               s1_q    <= 1'b1;
               state_q <= F_STEP;
            end
            F_STEP: begin
               k_q     <= k_d;
               state_q <= F_CHK;
            end
            F_CHK: begin
               if (!k_q[0] && tort_eq) begin
                  attr_q  <= s1_vec;
                  det_q   <= k_q;
                  s1_q    <= 1'b1;
                  state_q <= P_STEP;
               end else if (k_q == MAX_K) begin
                  tmo_q   <= 1'b1;
                  det_q   <= k_q;
                  per_q   <= '0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  s0_q    <= 1'b1;
                  s1_q    <= 1'b1;
                  state_q <= F_STEP;
               end
            end
            P_STEP: begin
               p_q     <= p_d;
               state_q <= P_CHK;
            end
            P_CHK: begin
               if (hare_eq) begin
                  per_q   <= p_q;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else if (kp_sum == MAX_KP) begin
                  tmo_q   <= 1'b1;
                  per_q   <= '0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  s1_q    <= 1'b1;
                  state_q <= P_STEP;
               end
            end
            DONE: begin
               if (result_ack) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign reset_nos    = rnos_q;
   assign init_state   = init_q;
   assign start_s0     = s0_q;
   assign start_s1     = s1_q;
   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign detect_steps = det_q;
   assign period       = per_q;
   assign attractor    = attr_q;
   assign timeout      = tmo_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - scoreboard bench for gnr_attractor_ctrl with a 4-node array model
module tb_gnr_attractor_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start        [2];
   logic [3:0]  init_vec     [2];
   logic        reset_nos    [2];
   logic [3:0]  init_state   [2];
   logic        start_s0     [2];
   logic        start_s1     [2];
   logic        busy         [2];
   logic        result_valid [2];
   logic        result_ack   [2];
   logic [31:0] detect_steps [2];
   logic [31:0] period       [2];
   logic [3:0]  attractor    [2];
   logic        timeout      [2];
   logic        model_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          inst;
      logic [31:0] det;
      logic [31:0] per;
      logic [3:0]  attr;
      logic        tmo;
      bit          chk_attr;
   } exp_t;
   exp_t exp_q[$];

   // Transient 0,1,2 then cycle {3,4,5,6}; model_id selects the identity map instead.
   function automatic logic [3:0] nxt(input logic [3:0] x, input logic id);
      if (id) return x;
      if (x < 4'd3) return x + 4'd1;
      return 4'd3 + ((x - 4'd2) % 4'd4);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic [3:0] s0_m   = '0;
      logic [3:0] s1_m   = '0;
      logic       pass_m = 1'b0;

      gnr_attractor_ctrl #(
         .N_NODES  (4),
         .CNT_W    (32),
         .MAX_STEPS((g == 0) ? (1 << 20) : 6)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .start       (start[g]),
         .init_vec    (init_vec[g]),
         .reset_nos   (reset_nos[g]),
         .init_state  (init_state[g]),
         .start_s0    (start_s0[g]),
         .start_s1    (start_s1[g]),
         .s0_vec      (s0_m),
         .s1_vec      (s1_m),
         .busy        (busy[g]),
         .result_valid(result_valid[g]),
         .result_ack  (result_ack[g]),
         .detect_steps(detect_steps[g]),
         .period      (period[g]),
         .attractor   (attractor[g]),
         .timeout     (timeout[g])
      );

      always @(posedge clk) begin
         if (reset_nos[g]) begin
            s0_m   <= init_state[g];
            s1_m   <= init_state[g];
            pass_m <= 1'b1;
         end else begin
            if (start_s1[g]) s1_m <= nxt(s1_m, model_id);
            if (start_s0[g]) begin
               if (pass_m) s0_m <= nxt(s0_m, model_id);
               pass_m <= ~pass_m;
            end
         end
      end
   end

   logic vprev [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin : mon
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         if (result_valid[i] === 1'b1 && vprev[i] !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_empty inst=%0d: result_valid with no expected entry", i);
            end else begin
               e = exp_q.pop_front();
               if (e.inst != i) begin
                  errors++;
                  $display("FAIL sb_inst: result from inst %0d, required inst %0d", i, e.inst);
               end
               checks++;
               if (detect_steps[i] !== e.det) begin
                  errors++;
                  $display("FAIL sb_detect_steps inst=%0d: got %0d, required %0d", i, detect_steps[i], e.det);
               end
               checks++;
               if (period[i] !== e.per) begin
                  errors++;
                  $display("FAIL sb_period inst=%0d: got %0d, required %0d", i, period[i], e.per);
               end
               checks++;
               if (timeout[i] !== e.tmo) begin
                  errors++;
                  $display("FAIL sb_timeout inst=%0d: got %b, required %b", i, timeout[i], e.tmo);
               end
               if (e.chk_attr) begin
                  checks++;
                  if (attractor[i] !== e.attr) begin
                     errors++;
                     $display("FAIL sb_attractor inst=%0d: got %h, required %h", i, attractor[i], e.attr);
                  end
               end
            end
         end
         vprev[i] <= result_valid[i];
      end
   end

   task automatic pulse_start(input int inst, input logic [3:0] v);
      init_vec[inst] = v;
      start[inst]    = 1'b1;
      @(negedge clk);
      start[inst]    = 1'b0;
   endtask

   task automatic wait_result(input int inst, output int rn_cnt, output int hyg);
      bit ok;
      ok     = 1'b0;
      rn_cnt = 0;
      hyg    = 0;
      for (int c = 0; c < 300 && !ok; c++) begin
         if (reset_nos[inst]) rn_cnt++;
         if ((reset_nos[inst] && (start_s0[inst] || start_s1[inst])) ||
             (start_s0[inst] && !start_s1[inst])) hyg++;
         if (result_valid[inst]) ok = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_result inst=%0d: result_valid not seen within 300 cycles", inst);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({busy[i], result_valid[i], reset_nos[i], start_s0[i], start_s1[i], timeout[i]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags inst=%0d: got %b, required 000000", i,
                     {busy[i], result_valid[i], reset_nos[i], start_s0[i], start_s1[i], timeout[i]});
         end
         checks++;
         if (detect_steps[i] !== 32'd0 || period[i] !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts inst=%0d: got %0d/%0d, required 0/0", i, detect_steps[i], period[i]);
         end
         checks++;
         if (init_state[i] !== 4'd0 || attractor[i] !== 4'd0) begin
            errors++;
            $display("FAIL reset_vecs inst=%0d: got %h/%h, required 0/0", i, init_state[i], attractor[i]);
         end
      end
   endtask

   task automatic test_attractor();
      int rn, hy;
      model_id = 1'b0;
      exp_q.push_back('{0, 32'd8, 32'd4, 4'd4, 1'b0, 1'b1});
      pulse_start(0, 4'd0);
      wait_result(0, rn, hy);
      checks++;
      if (rn != 1) begin errors++; $display("FAIL attr_reset_nos_count: got %0d, required 1", rn); end
      checks++;
      if (hy != 0) begin errors++; $display("FAIL attr_strobe_overlap: got %0d, required 0", hy); end
      checks++;
      if (busy[0] !== 1'b1) begin errors++; $display("FAIL attr_busy_in_done: got %b, required 1", busy[0]); end
      result_ack[0] = 1'b1;
      @(negedge clk);
      result_ack[0] = 1'b0;
      checks++;
      if (result_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL attr_after_ack: valid/busy got %b/%b, required 0/0", result_valid[0], busy[0]);
      end
   endtask

   task automatic test_fixed_point();
      int rn, hy;
      model_id = 1'b1;
      exp_q.push_back('{0, 32'd2, 32'd1, 4'd5, 1'b0, 1'b1});
      pulse_start(0, 4'd5);
      wait_result(0, rn, hy);
      checks++;
      if (init_state[0] !== 4'd5) begin errors++; $display("FAIL fp_init_state: got %h, required 5", init_state[0]); end
      checks++;
      if (rn != 1 || hy != 0) begin errors++; $display("FAIL fp_strobes: reset_nos %0d overlap %0d, required 1/0", rn, hy); end
      result_ack[0] = 1'b1;
      @(negedge clk);
      result_ack[0] = 1'b0;
      checks++;
      if (result_valid[0] !== 1'b0) begin errors++; $display("FAIL fp_after_ack: got %b, required 0", result_valid[0]); end
      model_id = 1'b0;
   endtask

   task automatic test_timeout();
      int rn, hy;
      model_id = 1'b0;
      exp_q.push_back('{1, 32'd6, 32'd0, 4'd0, 1'b1, 1'b0});
      pulse_start(1, 4'd0);
      wait_result(1, rn, hy);
      checks++;
      if (result_valid[1] !== 1'b1 || busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL tmo_valid_busy: got %b/%b, required 1/1", result_valid[1], busy[1]);
      end
      checks++;
      if (rn != 1 || hy != 0) begin errors++; $display("FAIL tmo_strobes: reset_nos %0d overlap %0d, required 1/0", rn, hy); end
      result_ack[1] = 1'b1;
      @(negedge clk);
      result_ack[1] = 1'b0;
      checks++;
      if (result_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL tmo_after_ack: valid/busy got %b/%b, required 0/0", result_valid[1], busy[1]);
      end
   endtask

   task automatic test_ignored_inputs();
      int rn, hy, rn0;
      bit seen;
      model_id = 1'b0;
      result_ack[0] = 1'b1;
      @(negedge clk);
      result_ack[0] = 1'b0;
      checks++;
      if (result_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL idle_ack: valid/busy got %b/%b, required 0/0", result_valid[0], busy[0]);
      end
      exp_q.push_back('{0, 32'd8, 32'd4, 4'd4, 1'b0, 1'b1});
      pulse_start(0, 4'd0);
      rn0  = 0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (reset_nos[0]) rn0++;
         if (start_s0[0] && start_s1[0]) seen = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL ign_no_fstep: F_STEP strobes not seen within 20 cycles"); end
      init_vec[0] = 4'd9;
      start[0]    = 1'b1;
      @(negedge clk);
      start[0]    = 1'b0;
      wait_result(0, rn, hy);
      checks++;
      if (rn0 + rn != 1) begin errors++; $display("FAIL ign_reset_nos_count: got %0d, required 1", rn0 + rn); end
      checks++;
      if (init_state[0] !== 4'd0) begin errors++; $display("FAIL ign_init_state: got %h, required 0", init_state[0]); end
      result_ack[0] = 1'b1;
      @(negedge clk);
      result_ack[0] = 1'b0;
   endtask

   task automatic test_rst_mid_run();
      int rn, hy;
      bit seen;
      model_id = 1'b0;
      pulse_start(0, 4'd0);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (start_s1[0] && !start_s0[0]) seen = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rst_no_pstep: P_STEP not seen within 100 cycles"); end
      @(negedge clk);
      checks++;
      if ({reset_nos[0], start_s0[0], start_s1[0]} !== 3'b000) begin
         errors++;
         $display("FAIL rst_cycle_strobes: got %b, required 000", {reset_nos[0], start_s0[0], start_s1[0]});
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy[0], result_valid[0], reset_nos[0], start_s0[0], start_s1[0]} !== 5'b0) begin
         errors++;
         $display("FAIL rst_after: busy/valid/strobes got %b, required 00000",
                  {busy[0], result_valid[0], reset_nos[0], start_s0[0], start_s1[0]});
      end
      @(negedge clk);
      checks++;
      if ({reset_nos[0], start_s0[0], start_s1[0]} !== 3'b000) begin
         errors++;
         $display("FAIL rst_next_strobes: got %b, required 000", {reset_nos[0], start_s0[0], start_s1[0]});
      end
      exp_q.push_back('{0, 32'd8, 32'd4, 4'd4, 1'b0, 1'b1});
      pulse_start(0, 4'd0);
      wait_result(0, rn, hy);
      result_ack[0] = 1'b1;
      @(negedge clk);
      result_ack[0] = 1'b0;
   endtask

   task automatic test_hold();
      int rn, hy;
      model_id = 1'b0;
      exp_q.push_back('{0, 32'd8, 32'd4, 4'd4, 1'b0, 1'b1});
      pulse_start(0, 4'd0);
      wait_result(0, rn, hy);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (result_valid[0] !== 1'b1 || busy[0] !== 1'b1 || detect_steps[0] !== 32'd8 ||
             period[0] !== 32'd4 || attractor[0] !== 4'd4 || timeout[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: v=%b b=%b d=%0d p=%0d a=%h t=%b, required 1 1 8 4 4 0", c,
                     result_valid[0], busy[0], detect_steps[0], period[0], attractor[0], timeout[0]);
         end
      end
      result_ack[0] = 1'b1;
      @(negedge clk);
      result_ack[0] = 1'b0;
      checks++;
      if (result_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL hold_ack: valid/busy got %b/%b, required 0/0", result_valid[0], busy[0]);
      end
      checks++;
      if (detect_steps[0] !== 32'd8 || period[0] !== 32'd4) begin
         errors++;
         $display("FAIL hold_fields_idle: got %0d/%0d, required 8/4", detect_steps[0], period[0]);
      end
   endtask

   initial begin
      rst      = 1'b1;
      model_id = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i]      = 1'b0;
         init_vec[i]   = 4'd0;
         result_ack[i] = 1'b0;
      end
      test_reset();
      test_attractor();
      test_fixed_point();
      test_timeout();
      test_ignored_inputs();
      test_rst_mid_run();
      test_hold();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d expected results never produced, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
